// File: rtl/led_seq_pkg.sv
// Shared mode encodings, bounce direction and pattern seeds for the LED sequencer.
package led_seq_pkg;

   localparam logic [1:0] MODE_ROL    = 2'b00;
   localparam logic [1:0] MODE_ROR    = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_BLINK  = 2'b11;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   // Blink starts from all LEDs lit; every other pattern starts from bit 0.
   function automatic logic [31:0] seed(input logic [1:0] mode, input int width);
      logic [63:0] ones;
      ones = (64'd1 << width) - 64'd1;
      return (mode == MODE_BLINK) ? ones[31:0] : 32'd1;
   endfunction

endpackage

// File: rtl/led_tick_div.sv
// Programmable tick divider: one tick every (DIV_MAX >> speed) + 1 enabled cycles.
module led_tick_div #(
   parameter int DIV_MAX = 5000000,
   parameter int SPEED_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [SPEED_W-1:0] speed,
   output logic               tick
);

   logic [31:0] limit;
   logic [31:0] count_q;
   logic [31:0] count_d;

   assign limit = 32'(DIV_MAX) >> speed;
   assign tick  = en && (count_q == 32'd0);

   // >= rather than == so a speed increase that strands count above the limit wraps at once.
   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = (count_q >= limit) ? 32'd0 : count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate-left, rotate-right, bounce and blink on a divided tick,
// with run/pause, runtime speed select and mode changes applied only on a tick.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int DIV_MAX = 5000000,
   parameter int SPEED_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [SPEED_W-1:0] speed,
   output logic [WIDTH-1:0]   led,
   output logic               step
);

   logic             tick;
   logic [WIDTH-1:0] led_q, led_d;
   logic             step_q, step_d;
   logic [1:0]       mode_q, mode_d;
   dir_e             dir_q, dir_d;
   logic [WIDTH-1:0] led_seed;
   logic [WIDTH-1:0] rol, ror, shl, shr;

   led_tick_div #(
      .DIV_MAX (DIV_MAX),
      .SPEED_W (SPEED_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .speed (speed),
      .tick  (tick)
   );

   assign led_seed = WIDTH'(seed(mode, WIDTH));

   // A single LED has nowhere to move, so every shift degenerates to a hold.
   generate
      if (WIDTH == 1) begin : g_narrow
         assign rol = led_q;
         assign ror = led_q;
         assign shl = led_q;
         assign shr = led_q;
      end else begin : g_wide
         assign rol = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
         assign ror = {led_q[0], led_q[WIDTH-1:1]};
         assign shl = led_q << 1;
         assign shr = led_q >> 1;
      end
   endgenerate

   always_comb begin
      led_d  = led_q;
      dir_d  = dir_q;
      mode_d = mode_q;
      step_d = tick;
      if (tick) begin
         if (mode != mode_q) begin
            mode_d = mode;
            dir_d  = DIR_LEFT;
            led_d  = led_seed;
         end else begin
            case (mode_q)
               MODE_ROL: led_d = rol;
               MODE_ROR: led_d = ror;
               MODE_BOUNCE: begin
                  if (dir_q == DIR_LEFT) begin
                     if (led_q[WIDTH-1]) begin
                        dir_d = DIR_RIGHT;
                        led_d = shr;
                     end else begin
                        led_d = shl;
                     end
                  end else begin
                     if (led_q[0]) begin
                        dir_d = DIR_LEFT;
                        led_d = shl;
                     end else begin
                        led_d = shr;
                     end
                  end
               end
               default: led_d = ~led_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q  <= WIDTH'(1);
         step_q <= 1'b0;
         mode_q <= MODE_ROL;
         dir_q  <= DIR_LEFT;
      end else begin
         led_q  <= led_d;
         step_q <= step_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
      end
   end

   assign led  = led_q;
   assign step = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with WIDTH=4, DIV_MAX=3; cycle 0 is the first cycle after rst falls.
module tb_led_sequencer;

   localparam int WIDTH   = 4;
   localparam int DIV_MAX = 3;
   localparam int SPEED_W = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic [1:0]         mode;
   logic [SPEED_W-1:0] speed;
   logic [WIDTH-1:0]   led;
   logic               step;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   led_sequencer #(
      .WIDTH   (WIDTH),
      .DIV_MAX (DIV_MAX),
      .SPEED_W (SPEED_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .speed (speed),
      .led   (led),
      .step  (step)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [1:0] m, input logic [SPEED_W-1:0] s);
      rst   = 1'b1;
      en    = 1'b1;
      mode  = m;
      speed = s;
      cyc(2);
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      en    = 1'b1;
      mode  = 2'b11;
      speed = 3'd2;
      cyc(3);
      n_cmp++;
      if (led !== 4'b0001) begin
         n_bad++;
         $display("FAIL reset_led: got %b expected %b", led, 4'b0001);
      end
      n_cmp++;
      if (step !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_step: got %b expected %b", step, 1'b0);
      end
      rst = 1'b0;
   endtask

   task automatic test_rotate_left();
      int k;
      logic [3:0] exp_led;
      logic       exp_step;
      do_reset(2'b00, 3'd0);
      for (int c = 1; c <= 16; c++) begin
         cyc(1);
         k        = (c - 1) / 4 + 1;
         exp_led  = 4'(1 << (k % 4));
         exp_step = ((c - 1) % 4 == 0);
         n_cmp++;
         if (led !== exp_led) begin
            n_bad++;
            $display("FAIL rol_led c%0d: got %b expected %b", c, led, exp_led);
         end
         n_cmp++;
         if (step !== exp_step) begin
            n_bad++;
            $display("FAIL rol_step c%0d: got %b expected %b", c, step, exp_step);
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] seq [8];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      do_reset(2'b10, 3'd0);
      for (int j = 0; j < 8; j++) begin
         cyc((j == 0) ? 1 : 4);
         n_cmp++;
         if (led !== seq[j]) begin
            n_bad++;
            $display("FAIL bounce_led tick%0d: got %b expected %b", j, led, seq[j]);
         end
         n_cmp++;
         if (step !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_step tick%0d: got %b expected %b", j, step, 1'b1);
         end
      end
   endtask

   task automatic test_mode_switch();
      do_reset(2'b00, 3'd0);
      cyc(5);
      n_cmp++;
      if (led !== 4'b0100) begin
         n_bad++;
         $display("FAIL sw_pre_led: got %b expected %b", led, 4'b0100);
      end
      cyc(1);
      mode = 2'b11;
      cyc(1);
      mode = 2'b01;
      cyc(1);
      n_cmp++;
      if (led !== 4'b0100) begin
         n_bad++;
         $display("FAIL sw_between_led: got %b expected %b", led, 4'b0100);
      end
      cyc(1);
      n_cmp++;
      if (led !== 4'b0001) begin
         n_bad++;
         $display("FAIL sw_reload_led: got %b expected %b", led, 4'b0001);
      end
      n_cmp++;
      if (step !== 1'b1) begin
         n_bad++;
         $display("FAIL sw_reload_step: got %b expected %b", step, 1'b1);
      end
      mode = 2'b11;
      cyc(4);
      n_cmp++;
      if (led !== 4'b1111) begin
         n_bad++;
         $display("FAIL blink_seed_led: got %b expected %b", led, 4'b1111);
      end
      cyc(4);
      n_cmp++;
      if (led !== 4'b0000) begin
         n_bad++;
         $display("FAIL blink_toggle_led: got %b expected %b", led, 4'b0000);
      end
   endtask

   task automatic test_speed();
      logic exp_b [6];
      exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset(2'b00, 3'd1);
      for (int c = 1; c <= 6; c++) begin
         cyc(1);
         n_cmp++;
         if (step !== (c % 2 == 1)) begin
            n_bad++;
            $display("FAIL speed1_step c%0d: got %b expected %b", c, step, (c % 2 == 1));
         end
      end
      // count is 2 in cycle 2; dropping the limit to 0 must wrap it on the next edge.
      do_reset(2'b00, 3'd0);
      cyc(2);
      speed = 3'd2;
      for (int c = 3; c <= 8; c++) begin
         cyc(1);
         n_cmp++;
         if (step !== exp_b[c-3]) begin
            n_bad++;
            $display("FAIL speed2_step c%0d: got %b expected %b", c, step, exp_b[c-3]);
         end
      end
      n_cmp++;
      if (led !== 4'b0100) begin
         n_bad++;
         $display("FAIL speed2_led: got %b expected %b", led, 4'b0100);
      end
   endtask

   task automatic test_pause();
      do_reset(2'b00, 3'd0);
      cyc(2);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         n_cmp++;
         if (led !== 4'b0010 || step !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_hold i%0d: got led=%b step=%b expected led=0010 step=0", i, led, step);
         end
      end
      en = 1'b1;
      cyc(2);
      n_cmp++;
      if (step !== 1'b0) begin
         n_bad++;
         $display("FAIL pause_phase_step: got %b expected %b", step, 1'b0);
      end
      cyc(1);
      n_cmp++;
      if (led !== 4'b0100 || step !== 1'b1) begin
         n_bad++;
         $display("FAIL pause_resume: got led=%b step=%b expected led=0100 step=1", led, step);
      end
   endtask

   task automatic test_reset_mid_bounce();
      do_reset(2'b10, 3'd0);
      cyc(17);
      n_cmp++;
      if (led !== 4'b0100) begin
         n_bad++;
         $display("FAIL midrst_pre_led: got %b expected %b", led, 4'b0100);
      end
      rst = 1'b1;
      cyc(1);
      n_cmp++;
      if (led !== 4'b0001 || step !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_state: got led=%b step=%b expected led=0001 step=0", led, step);
      end
      rst = 1'b0;
      cyc(1);
      n_cmp++;
      if (led !== 4'b0001 || step !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_first_tick: got led=%b step=%b expected led=0001 step=1", led, step);
      end
      cyc(4);
      n_cmp++;
      if (led !== 4'b0010) begin
         n_bad++;
         $display("FAIL midrst_next_led: got %b expected %b", led, 4'b0010);
      end
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      mode  = 2'b00;
      speed = '0;
      test_reset();
      test_rotate_left();
      test_bounce();
      test_mode_switch();
      test_speed();
      test_pause();
      test_reset_mid_bounce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
